fpga_fabric: RTL and testbench

- Small configurable logic fabric.
- 14 logic cells, each a 5-input LUT with an optional output flip-flop.
- Cell inputs and the 5 fabric outputs come from a routing pool: primary inputs A, B, c, d, all cell outputs, and constants.
- Configuration is written word-by-word through a synchronous config port. The top-level demonstrator uses it to build circuits such as a mod-16 up/down counter (c = increment, d = decrement).

---
 rtl/fpga_pkg.sv | 24 ++
 rtl/fpga_cell.sv | 52 +++++
 rtl/fpga_fabric.sv | 89 ++++++++
 tb/tb_fpga_fabric.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/fpga_pkg.sv
// Shared constants for the configurable logic fabric: routing source indices,
// config word base addresses and the 5-bit source-select type.
package fpga_pkg;

    localparam int NUM_CELLS = 14;
    localparam int LUT_K     = 5;
    localparam int NUM_OUTS  = 5;
    localparam int CFG_WORDS = 50;

    typedef logic [4:0] src_sel_t;

    localparam src_sel_t SRC_A0    = 5'd0;
    localparam src_sel_t SRC_B0    = 5'd4;
    localparam src_sel_t SRC_C     = 5'd8;
    localparam src_sel_t SRC_D     = 5'd9;
    localparam src_sel_t SRC_CELL0 = 5'd10;
    localparam src_sel_t SRC_ZERO  = 5'd24;
    localparam src_sel_t SRC_ONE   = 5'd25;

    localparam logic [5:0] CFG_TRUTH_BASE  = 6'd0;
    localparam logic [5:0] CFG_ROUTE_BASE  = 6'd28;
    localparam logic [5:0] CFG_OUTSEL_BASE = 6'd42;

endpackage

// File: rtl/fpga_cell.sv
// One fabric logic cell: 32-entry truth table, 5-input LUT and an optional
// output flip-flop. Readback taps exist only when FPGA_CFG_READBACK_EN is defined.
module fpga_cell
    import fpga_pkg::*;
#(
    parameter int CELL_IDX = 0
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [LUT_K-1:0] in,
    input  logic             cfg_we,
    input  logic [5:0]       cfg_addr,
    input  logic [31:0]      cfg_data,
    output logic             out
`ifdef FPGA_CFG_READBACK_EN
    ,
    output logic [31:0]      truth_o,
    output logic             mode_o
`endif
);

    localparam logic [5:0] TRUTH_ADDR = 6'(CFG_TRUTH_BASE + 2 * CELL_IDX);
    localparam logic [5:0] MODE_ADDR  = 6'(CFG_TRUTH_BASE + 2 * CELL_IDX + 1);

    logic [31:0] truth_q;
    logic        mode_q;
    logic        lut;
    logic        ff_d;
    logic        ff_q;

    // Config storage is deliberately not reset.
    always_ff @(posedge clock) begin
        if (cfg_we && cfg_addr == TRUTH_ADDR) truth_q <= cfg_data;
        if (cfg_we && cfg_addr == MODE_ADDR)  mode_q  <= cfg_data[0];
    end

    assign lut  = truth_q[in];
    assign ff_d = lut;

    always_ff @(posedge clock) begin
        if (!reset_n) ff_q <= 1'b0;
        else          ff_q <= ff_d;
    end

    assign out = mode_q ? ff_q : lut;

`ifdef FPGA_CFG_READBACK_EN
    assign truth_o = truth_q;
    assign mode_o  = mode_q;
`endif

endmodule

// File: rtl/fpga_fabric.sv
// Top of the configurable fabric: 14 LUT cells, input routing and output muxes.
// Optional config readback port cfg_rdata is enabled by FPGA_CFG_READBACK_EN.
module fpga_fabric
    import fpga_pkg::*;
(
    input  logic                clock,
    input  logic                reset_n,
    input  logic [3:0]          A,
    input  logic [3:0]          B,
    input  logic                c,
    input  logic                d,
    input  logic                cfg_we,
    input  logic [5:0]          cfg_addr,
    input  logic [31:0]         cfg_data,
`ifdef FPGA_CFG_READBACK_EN
    output logic [31:0]         cfg_rdata,
`endif
    output logic [NUM_OUTS-1:0] out
);

    logic [LUT_K*5-1:0]   route_q  [NUM_CELLS];
    src_sel_t             outsel_q [NUM_OUTS];
    logic [NUM_CELLS-1:0] cell_out;
    logic [31:0]          pool;

    // Source pool laid out so that a 5-bit select indexes it directly.
    assign pool = {6'b0, 1'b1, 1'b0, cell_out, d, c, B, A};

    always_ff @(posedge clock) begin
        for (int k = 0; k < NUM_CELLS; k++) begin
            if (cfg_we && cfg_addr == 6'(CFG_ROUTE_BASE + k))
                route_q[k] <= cfg_data[LUT_K*5-1:0];
        end
        for (int j = 0; j < NUM_OUTS; j++) begin
            if (cfg_we && cfg_addr == 6'(CFG_OUTSEL_BASE + j))
                outsel_q[j] <= cfg_data[4:0];
        end
    end

`ifdef FPGA_CFG_READBACK_EN
    logic [31:0] cell_truth [NUM_CELLS];
    logic        cell_mode  [NUM_CELLS];
`endif

    for (genvar k = 0; k < NUM_CELLS; k++) begin : g_cell
        logic [LUT_K-1:0] in_w;

        for (genvar i = 0; i < LUT_K; i++) begin : g_in
            assign in_w[i] = pool[route_q[k][5*i +: 5]];
        end

        fpga_cell #(
            .CELL_IDX (k)
        ) u_cell (
            .clock    (clock),
            .reset_n  (reset_n),
            .in       (in_w),
            .cfg_we   (cfg_we),
            .cfg_addr (cfg_addr),
            .cfg_data (cfg_data),
            .out      (cell_out[k])
`ifdef FPGA_CFG_READBACK_EN
            ,
            .truth_o  (cell_truth[k]),
            .mode_o   (cell_mode[k])
`endif
        );
    end

    for (genvar j = 0; j < NUM_OUTS; j++) begin : g_out
        assign out[j] = pool[outsel_q[j]];
    end

`ifdef FPGA_CFG_READBACK_EN
    // Unmatched (reserved) addresses fall through to zero.
    always_comb begin
        cfg_rdata = '0;
        for (int k = 0; k < NUM_CELLS; k++) begin
            if (cfg_addr == 6'(CFG_TRUTH_BASE + 2 * k))     cfg_rdata = cell_truth[k];
            if (cfg_addr == 6'(CFG_TRUTH_BASE + 2 * k + 1)) cfg_rdata = {31'b0, cell_mode[k]};
            if (cfg_addr == 6'(CFG_ROUTE_BASE + k))         cfg_rdata = {7'b0, route_q[k]};
        end
        for (int j = 0; j < NUM_OUTS; j++) begin
            if (cfg_addr == 6'(CFG_OUTSEL_BASE + j))        cfg_rdata = {27'b0, outsel_q[j]};
        end
    end
`endif

endmodule

// File: tb/tb_fpga_fabric.sv
// Scoreboard bench for fpga_fabric: passthrough, registered latency, a mod-16
// up/down counter built from cells, routing constants and (optional) readback.
module tb_fpga_fabric;
    import fpga_pkg::*;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [3:0]  A, B;
    logic        c, d;
    logic        cfg_we;
    logic [5:0]  cfg_addr;
    logic [31:0] cfg_data;
    logic [4:0]  out;
`ifdef FPGA_CFG_READBACK_EN
    logic [31:0] cfg_rdata;
`endif

    fpga_fabric dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .A        (A),
        .B        (B),
        .c        (c),
        .d        (d),
        .cfg_we   (cfg_we),
        .cfg_addr (cfg_addr),
        .cfg_data (cfg_data),
`ifdef FPGA_CFG_READBACK_EN
        .cfg_rdata(cfg_rdata),
`endif
        .out      (out)
    );

    always #5 clock = ~clock;

    typedef struct {
        string      tag;
        logic [4:0] mask;
        logic [4:0] val;
    } exp_t;

    exp_t       sb[$];
    int         n_checks = 0;
    int         n_pass   = 0;
    logic [3:0] cnt_model;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic cfg_wr(input logic [5:0] addr, input logic [31:0] data);
        cfg_we   = 1'b1;
        cfg_addr = addr;
        cfg_data = data;
        tick();
        cfg_we   = 1'b0;
    endtask

    task automatic expect_out(input string tag, input logic [4:0] mask, input logic [4:0] val);
        exp_t e;
        e.tag  = tag;
        e.mask = mask;
        e.val  = val;
        sb.push_back(e);
    endtask

    task automatic compare_out();
        exp_t e;
        #1;
        if (sb.size() == 0) begin
            check("sb_underflow", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check(e.tag, {27'b0, out & e.mask}, {27'b0, e.val & e.mask});
        end
    endtask

    function automatic logic [31:0] route(input src_sel_t s0, input src_sel_t s1,
                                          input src_sel_t s2, input src_sel_t s3,
                                          input src_sel_t s4);
        return {7'b0, s4, s3, s2, s1, s0};
    endfunction

    // Truth tables for the counter cells, written from the counting rule itself.
    function automatic logic [31:0] make_truth(input int kind);
        logic [31:0] t;
        logic b0, b1, b2, b3, b4, up, dn;
        t = '0;
        for (int i = 0; i < 32; i++) begin
            b0 = i[0]; b1 = i[1]; b2 = i[2]; b3 = i[3]; b4 = i[4];
            case (kind)
                0: t[i] = b0 ^ (b1 ^ b2);
                1: begin
                    up = b2 & ~b3; dn = b3 & ~b2;
                    t[i] = b0 ^ ((up & b1) | (dn & ~b1));
                end
                2: begin
                    up = b3 & ~b4; dn = b4 & ~b3;
                    t[i] = b0 ^ ((up & b1 & b2) | (dn & ~b1 & ~b2));
                end
                3: t[i] = b0 ^ b1;
                default: begin
                    up = b3 & ~b4; dn = b4 & ~b3;
                    t[i] = (up & b0 & b1 & b2) | (dn & ~b0 & ~b1 & ~b2);
                end
            endcase
        end
        return t;
    endfunction

    task automatic cnt_steps(input string tag, input logic ci, input logic di, input int n);
        for (int s = 0; s < n; s++) begin
            c = ci;
            d = di;
            if (ci && !di)      cnt_model = cnt_model + 4'd1;
            else if (di && !ci) cnt_model = cnt_model - 4'd1;
            expect_out(tag, 5'h0F, {1'b0, cnt_model});
            tick();
            compare_out();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
        $fatal(1);
    end

    initial begin
        reset_n  = 1'b0;
        A        = '0;
        B        = '0;
        c        = 1'b0;
        d        = 1'b0;
        cfg_we   = 1'b0;
        cfg_addr = '0;
        cfg_data = '0;
        tick();

        // Blank every cell and output, then build a passthrough on cell 0.
        for (int k = 0; k < NUM_CELLS; k++) begin
            cfg_wr(6'(2 * k), 32'h0);
            cfg_wr(6'(2 * k + 1), 32'h0);
            cfg_wr(6'(28 + k), route(SRC_ZERO, SRC_ZERO, SRC_ZERO, SRC_ZERO, SRC_ZERO));
        end
        for (int j = 0; j < NUM_OUTS; j++) cfg_wr(6'(42 + j), {27'b0, SRC_ZERO});
        cfg_wr(6'd0, 32'hAAAA_AAAA);
        cfg_wr(6'd28, route(SRC_A0, SRC_ZERO, SRC_ZERO, SRC_ZERO, SRC_ZERO));
        cfg_wr(6'd42, {27'b0, SRC_CELL0});
        reset_n = 1'b1;

        A = 4'b0001; expect_out("pass_a1", 5'h01, 5'h01); compare_out();
        A = 4'b0000; expect_out("pass_a0", 5'h01, 5'h00); compare_out();

        cfg_wr(6'd1, 32'h1);
        reset_n = 1'b0;
        tick();
        expect_out("reg_reset", 5'h01, 5'h00); compare_out();
        reset_n = 1'b1;
        A = 4'b0001;
        expect_out("reg_before_edge", 5'h01, 5'h00); compare_out();
        tick();
        expect_out("reg_after_edge", 5'h01, 5'h01); compare_out();
        A = 4'b0000;
        tick();
        expect_out("reg_fall", 5'h01, 5'h00); compare_out();

        // Counter: modes first so no combinational loop ever forms mid-config.
        for (int k = 0; k < 4; k++) cfg_wr(6'(2 * k + 1), 32'h1);
        cfg_wr(6'd9, 32'h0);
        for (int k = 0; k < 5; k++) cfg_wr(6'(2 * k), make_truth(k));
        cfg_wr(6'd28, route(5'd10, SRC_C, SRC_D, SRC_ZERO, SRC_ZERO));
        cfg_wr(6'd29, route(5'd11, 5'd10, SRC_C, SRC_D, SRC_ZERO));
        cfg_wr(6'd30, route(5'd12, 5'd10, 5'd11, SRC_C, SRC_D));
        cfg_wr(6'd31, route(5'd13, 5'd14, SRC_ZERO, SRC_ZERO, SRC_ZERO));
        cfg_wr(6'd32, route(5'd10, 5'd11, 5'd12, SRC_C, SRC_D));
        for (int j = 0; j < 4; j++) cfg_wr(6'(42 + j), {27'b0, 5'(10 + j)});

        reset_n = 1'b0;
        tick();
        reset_n   = 1'b1;
        cnt_model = 4'd0;
        expect_out("cnt_reset", 5'h0F, 5'h00); compare_out();

        cnt_steps("cnt_inc", 1'b1, 1'b0, 16);
        cnt_steps("cnt_dec", 1'b0, 1'b1, 5);
        cnt_steps("cnt_hold", 1'b0, 1'b0, 13);
        cnt_steps("cnt_resume", 1'b1, 1'b0, 14);

        reset_n = 1'b0;
        tick();
        reset_n   = 1'b1;
        cnt_model = 4'd0;
        expect_out("cnt_mid_reset", 5'h0F, 5'h00); compare_out();
        cnt_steps("cnt_after_reset", 1'b1, 1'b0, 3);
        c = 1'b0;

        cfg_wr(6'd46, {27'b0, SRC_ONE});
        expect_out("out4_const1", 5'h10, 5'h10); compare_out();
        cfg_wr(6'd46, {27'b0, SRC_ZERO});
        expect_out("out4_const0", 5'h10, 5'h00); compare_out();
        cfg_wr(6'd48, 32'hFFFF_FFFF);
        expect_out("rsvd_write", 5'h1F, {1'b0, cnt_model}); compare_out();

`ifdef FPGA_CFG_READBACK_EN
        cfg_wr(6'd28, 32'hFFFF_FFFF);
        cfg_addr = 6'd28; #1;
        check("rb_route28", cfg_rdata, 32'h01FF_FFFF);
        cfg_addr = 6'd1; #1;
        check("rb_mode1", cfg_rdata, 32'h0000_0001);
        cfg_addr = 6'd42; #1;
        check("rb_outsel42", cfg_rdata, 32'h0000_000A);
        cfg_addr = 6'd48; #1;
        check("rb_rsvd48", cfg_rdata, 32'h0);
`endif

        if (sb.size() != 0) check("sb_leftover", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
